// File: rtl/datapath_mc.sv
// Multicycle CPU datapath: PC, register file, operand/result registers, ALU, and a
// memory-transaction FSM (req/ack handshake, hard stall, timeout to error state).
module datapath_mc #(
  parameter  int              DATA_W   = 32,
  parameter  int              NREGS    = 16,
  parameter  logic [DATA_W-1:0] START_PC = '0,
  parameter  int              MEM_TMO  = 15,
  localparam int              RA_W     = $clog2(NREGS)
) (
  input  logic              iClk,
  input  logic              nRst,
  input  logic              iPC_nRst,
  input  logic              iPC_en,
  input  logic              iPC_jmp,
  input  logic              iPC_loadRA,
  input  logic              iPC_loadImm,
  input  logic              iRF_Write,
  input  logic [RA_W-1:0]   iRF_AddrA,
  input  logic [RA_W-1:0]   iRF_AddrB,
  input  logic [RA_W-1:0]   iRF_AddrC,
  input  logic              iRA_en,
  input  logic              iRB_en,
  input  logic [3:0]        iALU_Ctrl,
  input  logic              iRZ_en,
  input  logic              iRAS_en,
  input  logic              iMUX_B,
  input  logic              iMUX_RZHS,
  input  logic              iMUX_ASS,
  input  logic              iMUX_WB,
  input  logic              iMUX_MA,
  input  logic              iRWB_en,
  input  logic [DATA_W-1:0] iImm,
  input  logic              iMemRd,
  input  logic              iMemWr,
  input  logic              iErrClr,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [DATA_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  input  logic [DATA_W-1:0] iMemData,
  input  logic              iMemAck,
  output logic              oBusy,
  output logic              oMemErr,
  output logic              oALU_zero,
  output logic              oALU_neg
);

  localparam int         SH_W = $clog2(DATA_W);
  localparam logic [7:0] TMO  = 8'(MEM_TMO);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ERR} mem_state_t;

  mem_state_t        state, state_nxt;
  logic [7:0]        tmo_cnt, tmo_cnt_nxt;
  logic              busy, mem_start;
  logic              we_q;
  logic [DATA_W-1:0] addr_q, data_q;

  logic [DATA_W-1:0] rf [NREGS];
  logic [DATA_W-1:0] pc, ra, rb, rzh, rzl, rash, rasl, rwb;
  logic [DATA_W-1:0] rz, ras, rzx, alu_b, alu_hi, alu_lo, pc_plus4, ma_live;
  logic [2*DATA_W-1:0] prod;
  logic [SH_W-1:0]   sh;

  assign busy      = (state != S_IDLE);
  assign mem_start = (state == S_IDLE) && (iMemRd || iMemWr);

  assign rz       = iMUX_RZHS ? rzh : rzl;
  assign ras      = iMUX_RZHS ? rash : rasl;
  assign rzx      = iMUX_ASS ? ras : rz;
  assign alu_b    = iMUX_B ? iImm : rb;
  assign sh       = alu_b[SH_W-1:0];
  assign pc_plus4 = pc + DATA_W'(4);
  assign ma_live  = iMUX_MA ? rzx : pc;

  assign prod = $signed({{DATA_W{ra[DATA_W-1]}}, ra}) * $signed({{DATA_W{alu_b[DATA_W-1]}}, alu_b});

  always_comb begin
    alu_hi = '0;
    alu_lo = ra;
    case (iALU_Ctrl)
      4'h0: alu_lo = ra + alu_b;
      4'h1: alu_lo = ra - alu_b;
      4'h2: alu_lo = ra & alu_b;
      4'h3: alu_lo = ra | alu_b;
      4'h4: alu_lo = ra ^ alu_b;
      4'h5: alu_lo = ra << sh;
      4'h6: alu_lo = ra >> sh;
      4'h7: alu_lo = $signed(ra) >>> sh;
      4'h8: {alu_hi, alu_lo} = prod;
      4'h9: alu_lo = ~ra;
      4'hA: alu_lo = -ra;
      4'hB: alu_lo = alu_b;
      default: alu_lo = ra;
    endcase
  end

  assign oALU_zero = (alu_lo == '0);
  assign oALU_neg  = alu_lo[DATA_W-1];

  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    case (state)
      S_IDLE: if (iMemRd || iMemWr) begin
        state_nxt   = S_REQ;
        tmo_cnt_nxt = 8'd1;
      end
      // ack is checked before the limit so an ack on the final cycle still succeeds
      S_REQ: begin
        if (iMemAck)             state_nxt   = S_IDLE;
        else if (tmo_cnt >= TMO) state_nxt   = S_ERR;
        else                     tmo_cnt_nxt = tmo_cnt + 8'd1;
      end
      S_ERR: if (iErrClr) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state   <= S_IDLE;
      tmo_cnt <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      if (mem_start) begin
        we_q   <= iMemWr;
        addr_q <= ma_live;
        data_q <= rb;
      end
    end
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
      pc   <= START_PC;
      ra   <= '0;
      rb   <= '0;
      rzh  <= '0;
      rzl  <= '0;
      rash <= '0;
      rasl <= '0;
      rwb  <= '0;
    end else if (!busy) begin
      if (!iPC_nRst)    pc <= START_PC;
      else if (iPC_jmp) pc <= iPC_loadRA ? ra : (iPC_loadImm ? pc_plus4 + iImm : pc_plus4);
      else if (iPC_en)  pc <= pc_plus4;
      if (iRF_Write) rf[iRF_AddrC] <= rwb;
      if (iRA_en)    ra <= rf[iRF_AddrA];
      if (iRB_en)    rb <= rf[iRF_AddrB];
      if (iRZ_en) begin
        rzh <= alu_hi;
        rzl <= alu_lo;
      end
      if (iRAS_en) begin
        rash <= alu_hi;
        rasl <= alu_lo;
      end
      if (iRWB_en) rwb <= iMUX_WB ? rzx : iMemData;
    end else if (state == S_REQ && iMemAck && !we_q) begin
      rwb <= iMemData;
    end
  end

  assign oMemReq  = (state == S_REQ);
  assign oMemWe   = we_q;
  assign oMemErr  = (state == S_ERR);
  assign oBusy    = busy;
  assign oMemAddr = busy ? addr_q : ma_live;
  assign oMemData = busy ? data_q : rb;

endmodule
